// File: rtl/dsp_pkg.sv
// Shared DSP datapath definitions: default word width, subtractor FSM states
// and the digit-counter width helper.
package dsp_pkg;

  localparam int unsigned DSP_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

  // Counter must hold N-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/borrow_digit_sub.sv
// Combinational DIGIT-bit subtract slice: {borrow_out, d} = a_dig - b_dig - borrow_in.
module borrow_digit_sub #(
  parameter int unsigned DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             borrow_in,
  output logic [DIGIT-1:0] d,
  output logic             borrow_out
);

  // A negative (DIGIT+1)-bit difference always has its top bit set.
  always_comb begin
    {borrow_out, d} = {1'b0, a_dig} - {1'b0, b_dig} - {{DIGIT{1'b0}}, borrow_in};
  end

endmodule

// File: rtl/serial_borrow_subtractor.sv
// Digit-serial subtractor: diff = a - b - bin over WIDTH/DIGIT cycles with
// borrow-out, signed overflow and valid/ready handshakes on both sides.
module serial_borrow_subtractor
  import dsp_pkg::*;
#(
  parameter int unsigned WIDTH = DSP_WIDTH,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int unsigned N  = WIDTH / DIGIT;
  localparam int unsigned CW = cnt_width(N);

  sub_state_t       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic             a_sign;
  logic             b_sign;
  logic [CW-1:0]    cnt;
  logic [DIGIT-1:0] d_dig;
  logic             borrow_nxt;

  borrow_digit_sub #(.DIGIT(DIGIT)) u_dig (
    .a_dig      (a_sr[DIGIT-1:0]),
    .b_dig      (b_sr[DIGIT-1:0]),
    .borrow_in  (borrow),
    .d          (d_dig),
    .borrow_out (borrow_nxt)
  );

  // New digit enters at the top; after N shifts the first digit sits at bit 0.
  if (DIGIT < WIDTH) begin : g_shift
    assign res_next = {d_dig, res_sr[WIDTH-1:DIGIT]};
  end else begin : g_full
    assign res_next = d_dig;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      bout      <= 1'b0;
      ovf       <= 1'b0;
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      borrow    <= 1'b0;
      a_sign    <= 1'b0;
      b_sign    <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_sr     <= a;
            b_sr     <= b;
            borrow   <= bin;
            a_sign   <= a[WIDTH-1];
            b_sign   <= b[WIDTH-1];
            res_sr   <= '0;
            cnt      <= CW'(N - 1);
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> DIGIT;
          b_sr   <= b_sr >> DIGIT;
          res_sr <= res_next;
          borrow <= borrow_nxt;
          cnt    <= cnt - 1'b1;
          if (cnt == '0) begin
            diff      <= res_next;
            bout      <= borrow_nxt;
            ovf       <= (a_sign != b_sign) && (res_next[WIDTH-1] != a_sign);
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_borrow_subtractor.sv
// Directed self-checking bench for serial_borrow_subtractor (DIGIT=1 and DIGIT=4 builds).
module tb_serial_borrow_subtractor;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic        bin;
  logic        ordy;
  logic        iv1, ir1, ov1, bo1, of1;
  logic [15:0] d1;
  logic        iv4, ir4, ov4, bo4, of4;
  logic [15:0] d4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_borrow_subtractor #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
    .a(a), .b(b), .bin(bin), .out_valid(ov1), .out_ready(ordy),
    .diff(d1), .bout(bo1), .ovf(of1)
  );

  serial_borrow_subtractor #(.WIDTH(16), .DIGIT(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4),
    .a(a), .b(b), .bin(bin), .out_valid(ov4), .out_ready(ordy),
    .diff(d4), .bout(bo4), .ovf(of4)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } vec_t;

  // Issue one operation, time it from the accept edge, capture and release the result.
  task automatic run_op(input bit sel, input logic [15:0] ta, input logic [15:0] tb,
                        input logic tbin, output int lat, output logic [15:0] rd,
                        output logic rb, output logic ro);
    int guard;
    lat = -1;
    @(negedge clk);
    guard = 0;
    while (!(sel ? ir4 : ir1) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    a = ta; b = tb; bin = tbin;
    if (sel) iv4 = 1'b1; else iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0; iv4 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (sel ? ov4 : ov1) begin
        lat = i;
        break;
      end
    end
    rd = sel ? d4 : d1;
    rb = sel ? bo4 : bo1;
    ro = sel ? of4 : of1;
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
  endtask

  task automatic test_reset();
    int seen;
    reset = 1'b1; iv1 = 1'b0; iv4 = 1'b0; ordy = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir1); end
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov1); end
    checks++; if ({d1, bo1, of1} !== 18'h0) begin errors++; $display("FAIL reset_outputs got %h/%b/%b want 0000/0/0", d1, bo1, of1); end
    checks++; if (ir4 !== 1'b1 || ov4 !== 1'b0) begin errors++; $display("FAIL reset_dig4 got ir=%b ov=%b want 1/0", ir4, ov4); end
    // reset and in_valid together: nothing may be accepted
    a = 16'h0005; b = 16'h0003; iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0; reset = 1'b0;
    checks++; if (ir1 !== 1'b1) begin errors++; $display("FAIL reset_wins_in_ready got %b want 1", ir1); end
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL reset_wins_no_valid got %0d want 0", seen); end
  endtask

  task automatic test_vectors();
    vec_t vt[5];
    int lat;
    logic [15:0] rd;
    logic rb, ro;
    vt[0] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
    vt[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vt[2] = '{16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vt[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vt[4] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      run_op(1'b0, vt[i].a, vt[i].b, vt[i].bin, lat, rd, rb, ro);
      checks++; if (lat !== 16) begin errors++; $display("FAIL vec%0d_latency got %0d want 16", i, lat); end
      checks++; if (rd !== vt[i].d) begin errors++; $display("FAIL vec%0d_diff got %h want %h", i, rd, vt[i].d); end
      checks++; if (rb !== vt[i].bo) begin errors++; $display("FAIL vec%0d_bout got %b want %b", i, rb, vt[i].bo); end
      checks++; if (ro !== vt[i].ov) begin errors++; $display("FAIL vec%0d_ovf got %b want %b", i, ro, vt[i].ov); end
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge clk);
    a = 16'h0100; b = 16'h0001; bin = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'h1111; bin = 1'b1;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      iv1 = ~iv1;
      @(posedge clk);
      @(negedge clk);
      if (ov1) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 16) begin errors++; $display("FAIL bp_latency got %0d want 16", lat); end
    for (int k = 0; k < 5; k++) begin
      iv1 = ~iv1;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (ov1 !== 1'b1 || ir1 !== 1'b0 || d1 !== 16'h00FF || bo1 !== 1'b0 || of1 !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b ir=%b diff=%h bout=%b ovf=%b want 1/0/00ff/0/0", k, ov1, ir1, d1, bo1, of1);
      end
    end
    // release with a pending request: it must not be taken on the release edge
    a = 16'h0003; b = 16'h0004; bin = 1'b0; iv1 = 1'b1; ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
    checks++; if (ov1 !== 1'b0 || ir1 !== 1'b1) begin errors++; $display("FAIL bp_release got ov=%b ir=%b want 0/1", ov1, ir1); end
    checks++; if (d1 !== 16'h00FF) begin errors++; $display("FAIL bp_diff_kept got %h want 00ff", d1); end
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    checks++; if (ir1 !== 1'b0) begin errors++; $display("FAIL bp_accept_n2 got in_ready=%b want 0", ir1); end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (ov1) begin
        lat = i;
        break;
      end
    end
    checks++; if (lat !== 16 || d1 !== 16'hFFFF || bo1 !== 1'b1 || of1 !== 1'b0) begin
      errors++;
      $display("FAIL bp_second got lat=%0d diff=%h bout=%b ovf=%b want 16/ffff/1/0", lat, d1, bo1, of1);
    end
    ordy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ordy = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int seen, lat;
    logic [15:0] rd;
    logic rb, ro;
    @(negedge clk);
    a = 16'h4321; b = 16'h0001; bin = 1'b0; iv1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv1 = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({d1, bo1, of1} !== 18'h0) begin errors++; $display("FAIL midrun_outputs got %h/%b/%b want 0000/0/0", d1, bo1, of1); end
    checks++; if (ir1 !== 1'b1 || ov1 !== 1'b0) begin errors++; $display("FAIL midrun_handshake got ir=%b ov=%b want 1/0", ir1, ov1); end
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (ov1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrun_dropped got %0d valid cycles want 0", seen); end
    run_op(1'b0, 16'h0010, 16'h0001, 1'b0, lat, rd, rb, ro);
    checks++; if (lat !== 16 || rd !== 16'h000F || rb !== 1'b0 || ro !== 1'b0) begin
      errors++;
      $display("FAIL midrun_fresh got lat=%0d diff=%h bout=%b ovf=%b want 16/000f/0/0", lat, rd, rb, ro);
    end
  endtask

  task automatic test_digit4();
    int lat;
    logic [15:0] rd;
    logic rb, ro;
    run_op(1'b1, 16'hA5A5, 16'h5A5A, 1'b0, lat, rd, rb, ro);
    checks++; if (lat !== 4) begin errors++; $display("FAIL d4_latency got %0d want 4", lat); end
    checks++; if (rd !== 16'h4B4B || rb !== 1'b0 || ro !== 1'b1) begin
      errors++;
      $display("FAIL d4_a5a5 got diff=%h bout=%b ovf=%b want 4b4b/0/1", rd, rb, ro);
    end
    run_op(1'b1, 16'h0000, 16'h0000, 1'b1, lat, rd, rb, ro);
    checks++; if (lat !== 4 || rd !== 16'hFFFF || rb !== 1'b1 || ro !== 1'b0) begin
      errors++;
      $display("FAIL d4_zero_bin got lat=%0d diff=%h bout=%b ovf=%b want 4/ffff/1/0", lat, rd, rb, ro);
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_reset_midrun();
    test_digit4();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_borrow_subtractor.md
Name: serial_borrow_subtractor

Overview:
Multi-cycle, digit-serial subtractor: computes diff = a - b - bin over WIDTH/DIGIT cycles and produces borrow-out and signed-overflow flags. It is the subtract-side counterpart of the datapath's combinational ripple-carry adder. It trades latency for area in the DSP datapath and uses a valid/ready handshake on both input and output.

Parameters:
WIDTH, 16, operand and result width in bits
DIGIT, 1, bits processed per cycle; must divide WIDTH (legal: 1, 2, 4, 8, 16)

Ports:
clk        input   1      system clock, rising edge
reset      input   1      synchronous, active-high reset
in_valid   input   1      operands a, b, bin are valid
in_ready   output  1      block can accept an operation
a          input   WIDTH  minuend
b          input   WIDTH  subtrahend
bin        input   1      borrow-in
out_valid  output  1      diff, bout, ovf are valid
out_ready  input   1      consumer accepts the result
diff       output  WIDTH  a - b - bin, modulo 2^WIDTH
bout       output  1      borrow-out (1 when a < b + bin, unsigned)
ovf        output  1      signed (two's-complement) overflow

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Let N = WIDTH/DIGIT.
- FSM has three states: IDLE, RUN, DONE.
- Reset values: state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0. Internal shift registers and digit counter are cleared.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b, bin, and the sign bits of a and b; load digit counter with N-1; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - Each edge processes the DIGIT LSBs: {borrow, d} = a_dig - b_dig - borrow.
  - Shift the operand registers right by DIGIT. Shift d into the top of the result register.
  - Decrement the counter.
  - When counter==0 on a processing edge: load diff from the completed result, bout from the final borrow, and ovf = (a_sign != b_sign) && (diff_sign != a_sign). Then go to DONE.
- DONE:
  - out_valid=1.
  - diff, bout, and ovf stay stable while out_valid && !out_ready.
  - On out_ready: go to IDLE, out_valid=0. diff, bout, and ovf keep their values until the next DONE entry.
- Latency: the operation is accepted at edge t0, and out_valid is high after edge t0+N.
- Minimum issue interval is N+2 cycles. There is no accept-while-draining bypass.
- bin=1 with a==b gives diff=all-ones, bout=1.
- Arithmetic wraps modulo 2^WIDTH. No saturation.
- Reset mid-RUN or mid-DONE:
  - The transaction is dropped with no out_valid pulse.
  - All outputs return to reset values on that edge.
  - in_ready=1 on the following cycle.
- If reset and in_valid are asserted in the same cycle, reset wins and nothing is accepted.
- If out_ready is high while out_valid=0, it has no effect.

Decomposition:
- dsp_pkg holds:
  - sub_state_t enum {IDLE, RUN, DONE}
  - a localparam helper for counter width, $clog2(N) with a minimum of 1
  - the default WIDTH constant shared with the adder path
- One natural sub-module: borrow_digit_sub. It is a combinational DIGIT-bit slice with inputs a_dig, b_dig, borrow_in and outputs d, borrow_out, instantiated once in the datapath.

Test Plan:
- WIDTH=16, DIGIT=1: a=0x0005, b=0x0003, bin=0 -> diff=0x0002, bout=0, ovf=0; out_valid rises exactly 16 cycles after the accept edge.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Then a=0x1234, b=0x1234, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. Then a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> diff, bout, ovf stable and in_ready=0. Toggling in_valid with new operands during RUN/DONE is ignored. The next accept occurs at t0+N+2 at the earliest.
- Reset asserted on the 7th RUN cycle -> outputs read 0 and in_ready=1 on the next cycle, and no out_valid occurs. A fresh a=0x0010, b=0x0001 then yields diff=0x000F.
- DIGIT=4 build: a=0xA5A5, b=0x5A5A, bin=0 -> diff=0x4B4B, bout=0, ovf=1; out_valid rises 4 cycles after accept.
